message_scroller: RTL and testbench

- Upstream frame source for the 5x7 LED-matrix scan path (divider, row counter, row demux, column muxes).
- Holds a static message bitmap, maintains a wrap-around scroll position and emits a registered WIN_H x WIN_W window frame.
- Runs its own step-rate prescaler. Frame updates only at the scanner's frame boundary (frame_sync), so a scan never shows a torn frame.
- A two-bit user mode (from the two selection switches) selects off, scroll left, scroll right or freeze.

---
 rtl/message_scroller_pkg.sv | 15 +
 rtl/message_scroller_if.sv | 30 +++
 rtl/message_scroller_step_prescaler.sv | 29 ++
 rtl/message_scroller.sv | 109 ++++++++++
 tb/tb_message_scroller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/message_scroller_pkg.sv
// Shared definitions for the message scroller: user mode encodings and the
// default LED-matrix geometry.
package message_scroller_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    localparam int DEFAULT_WIN_W = 7;
    localparam int DEFAULT_WIN_H = 5;

endpackage

// File: rtl/message_scroller_if.sv
// Bundle between the frame source and its user/scanner side: mode, bitmap and
// frame_sync in, registered window frame and status out.
interface message_scroller_if
    import message_scroller_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int WIN_W   = DEFAULT_WIN_W,
    parameter int WIN_H   = DEFAULT_WIN_H
);
    localparam int POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [1:0]               mode;
    logic [WIN_H*MSG_LEN-1:0] msg_bits;
    logic                     frame_sync;
    logic [WIN_H*WIN_W-1:0]   frame_out;
    logic                     display_en;
    logic [POS_W-1:0]         pos;
    logic                     step_pulse;

    modport master (
        output mode, msg_bits, frame_sync,
        input  frame_out, display_en, pos, step_pulse
    );

    modport slave (
        input  mode, msg_bits, frame_sync,
        output frame_out, display_en, pos, step_pulse
    );

endinterface

// File: rtl/message_scroller_step_prescaler.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 while running and flags the
// terminal count combinationally; held at zero when stopped.
module step_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(TICK_DIV - 1));
    assign tick   = run && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!run || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/message_scroller.sv
// Scrolling frame source for the 5x7 LED matrix: keeps a wrap-around scroll
// offset into a static bitmap and publishes a window only at frame boundaries.
module message_scroller
    import message_scroller_pkg::*;
#(
    parameter int MSG_LEN  = 16,
    parameter int WIN_W    = DEFAULT_WIN_W,
    parameter int WIN_H    = DEFAULT_WIN_H,
    parameter int TICK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               rst_n,
    message_scroller_if.slave  bus
);
    localparam int POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int IDX_W = POS_W + 1;

    logic                   w_run;
    logic                   w_left;
    logic                   w_active;
    logic                   w_tick;
    logic                   w_do_step;
    logic [POS_W-1:0]       w_pos_next;
    logic [WIN_H*WIN_W-1:0] w_window;

    logic [POS_W-1:0]       r_pos;
    logic                   r_pending;
    logic [WIN_H*WIN_W-1:0] r_frame;
    logic                   r_display_en;
    logic                   r_step_pulse;

    assign w_left   = (bus.mode == MODE_LEFT);
    assign w_run    = w_left || (bus.mode == MODE_RIGHT);
    assign w_active = (bus.mode != MODE_OFF);

    step_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    // A tick landing on the frame_sync cycle counts just like a pending one.
    assign w_do_step = w_run && bus.frame_sync && (r_pending || w_tick);

    always_comb begin
        w_pos_next = r_pos;
        if (w_do_step) begin
            if (w_left) begin
                w_pos_next = (r_pos == POS_W'(MSG_LEN - 1)) ? '0 : r_pos + POS_W'(1);
            end else begin
                w_pos_next = (r_pos == '0) ? POS_W'(MSG_LEN - 1) : r_pos - POS_W'(1);
            end
        end
    end

    // Window column c reads message column (pos_next + c) wrapped by one subtract.
    for (genvar gr = 0; gr < WIN_H; gr++) begin : g_row
        logic [MSG_LEN-1:0] w_row;
        assign w_row = bus.msg_bits[gr*MSG_LEN +: MSG_LEN];

        for (genvar gc = 0; gc < WIN_W; gc++) begin : g_col
            logic [IDX_W-1:0] w_sum;
            logic [POS_W-1:0] w_col;
            assign w_sum = {1'b0, w_pos_next} + IDX_W'(gc);
            assign w_col = (w_sum >= IDX_W'(MSG_LEN)) ? POS_W'(w_sum - IDX_W'(MSG_LEN))
                                                      : w_sum[POS_W-1:0];
            assign w_window[gr*WIN_W + gc] = w_row[w_col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos        <= '0;
            r_pending    <= 1'b0;
            r_frame      <= '0;
            r_display_en <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_pos        <= w_pos_next;
            r_step_pulse <= w_do_step;

            if (!w_run || w_do_step) begin
                r_pending <= 1'b0;
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end

            if (bus.frame_sync && w_active) begin
                r_frame <= w_window;
            end

            // Going dark must not wait for the scanner's next frame boundary.
            if (!w_active) begin
                r_display_en <= 1'b0;
            end else if (bus.frame_sync) begin
                r_display_en <= 1'b1;
            end
        end
    end

    assign bus.frame_out  = r_frame;
    assign bus.display_en = r_display_en;
    assign bus.pos        = r_pos;
    assign bus.step_pulse = r_step_pulse;

endmodule

// File: tb/tb_message_scroller.sv
// Randomized self-checking bench for message_scroller against a cycle-level
// behavioural model built from modulo arithmetic.
module tb_message_scroller;
    import message_scroller_pkg::*;

    localparam int MSG_LEN  = 16;
    localparam int WIN_W    = 7;
    localparam int WIN_H    = 5;
    localparam int TICK_DIV = 4;
    localparam int FW       = WIN_H * WIN_W;
    localparam int MW       = WIN_H * MSG_LEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    message_scroller_if #(.MSG_LEN(MSG_LEN), .WIN_W(WIN_W), .WIN_H(WIN_H)) bus ();

    message_scroller #(
        .MSG_LEN  (MSG_LEN),
        .WIN_W    (WIN_W),
        .WIN_H    (WIN_H),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          m_pos;
    int          m_cnt;
    bit          m_pend;
    bit          m_den;
    bit          m_sp;
    logic [FW-1:0] m_frame;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] window(input int p, input logic [MW-1:0] m);
        logic [FW-1:0] f;
        logic [MW-1:0] sh;
        f = '0;
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
                sh = m >> (r * MSG_LEN + (p + c) % MSG_LEN);
                f  = f | (FW'(sh[0]) << (r * WIN_W + c));
            end
        end
        return f;
    endfunction

    // One clock: model predicts from current inputs, DUT is sampled 1 time unit after the edge.
    task automatic step_clk();
        bit run, tick, stp;
        int np;
        run  = (bus.mode == 2'b01) || (bus.mode == 2'b10);
        tick = run && (m_cnt == TICK_DIV - 1);
        stp  = run && bus.frame_sync && (m_pend || tick);
        np   = m_pos;
        if (stp) np = (bus.mode == 2'b01) ? (m_pos + 1) % MSG_LEN : (m_pos + MSG_LEN - 1) % MSG_LEN;
        @(posedge clk);
        #1;
        if (bus.frame_sync && bus.mode != 2'b00) m_frame = window(np, bus.msg_bits);
        if (bus.mode == 2'b00) m_den = 1'b0;
        else if (bus.frame_sync) m_den = 1'b1;
        m_sp  = stp;
        m_pos = np;
        if (!run || stp) m_pend = 1'b0;
        else if (tick) m_pend = 1'b1;
        m_cnt = run ? (m_cnt + 1) % TICK_DIV : 0;
        chk("pos", 64'(bus.pos), 64'(m_pos));
        chk("frame", 64'(bus.frame_out), 64'(m_frame));
        chk("display_en", 64'(bus.display_en), 64'(m_den));
        chk("step_pulse", 64'(bus.step_pulse), 64'(m_sp));
    endtask

    task automatic run_frame(input int period);
        bus.frame_sync = 1'b0;
        repeat (period - 1) step_clk();
        bus.frame_sync = 1'b1;
        step_clk();
        bus.frame_sync = 1'b0;
    endtask

    // Reset asserted away from the clock edge; outputs must clear before the next edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_pos = 0; m_cnt = 0; m_pend = 1'b0; m_den = 1'b0; m_sp = 1'b0; m_frame = '0;
        chk("rst_pos", 64'(bus.pos), 64'd0);
        chk("rst_frame", 64'(bus.frame_out), 64'd0);
        chk("rst_display_en", 64'(bus.display_en), 64'd0);
        chk("rst_step_pulse", 64'(bus.step_pulse), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [MW-1:0] rand_msg();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < (MW + 31) / 32; i++) m = (m << 32) | MW'($urandom);
        return m;
    endfunction

    initial begin
        logic [MW-1:0] msg0;
        logic [MW-1:0] msg1;
        int p0;
        int guard;

        msg0 = '0;
        msg0[15:0] = 16'hA0EE;
        bus.mode       = 2'b00;
        bus.msg_bits   = msg0;
        bus.frame_sync = 1'b0;
        do_reset();

        // Scroll left with a frame_sync every 10 cycles.
        bus.mode = 2'b01;
        repeat (5) step_clk();
        chk("pre_frame", 64'(bus.frame_out), 64'd0);
        chk("pre_display_en", 64'(bus.display_en), 64'd0);
        run_frame(10);
        chk("first_pos", 64'(bus.pos), 64'd1);
        chk("first_display_en", 64'(bus.display_en), 64'd1);
        chk("first_frame", 64'(bus.frame_out), 64'(window(1, msg0)));
        for (int i = 0; i < 17; i++) begin
            p0 = m_pos;
            run_frame(10);
            chk("left_inc", 64'(bus.pos), 64'((p0 + 1) % MSG_LEN));
            chk("left_pulse", 64'(bus.step_pulse), 64'd1);
        end

        // Scroll right through the 0 -> 15 wrap.
        bus.mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            p0 = m_pos;
            run_frame(10);
            chk("right_dec", 64'(bus.pos), 64'((p0 + MSG_LEN - 1) % MSG_LEN));
        end

        // Slow frames: several ticks per interval still give a single step.
        bus.mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            p0 = m_pos;
            run_frame(20);
            chk("no_accum_pos", 64'(bus.pos), 64'((p0 + 1) % MSG_LEN));
        end

        // frame_sync coinciding with the tick while nothing is pending.
        guard = 0;
        while (!(m_cnt == TICK_DIV - 1 && !m_pend) && guard < 4 * TICK_DIV) begin
            step_clk();
            guard++;
        end
        chk("coincide_align", 64'(guard < 4 * TICK_DIV), 64'd1);
        p0 = m_pos;
        bus.frame_sync = 1'b1;
        step_clk();
        chk("coincide_pulse", 64'(bus.step_pulse), 64'd1);
        chk("coincide_pos", 64'(bus.pos), 64'((p0 + 1) % MSG_LEN));
        step_clk();
        bus.frame_sync = 1'b0;
        chk("coincide_pending_clear", 64'(bus.step_pulse), 64'd0);

        // Freeze: no stepping, but frames still refresh from a new bitmap.
        repeat (2) step_clk();
        bus.mode = 2'b11;
        p0 = m_pos;
        msg1 = rand_msg();
        bus.msg_bits = msg1;
        run_frame(10);
        chk("freeze_pos", 64'(bus.pos), 64'(p0));
        chk("freeze_pulse", 64'(bus.step_pulse), 64'd0);
        chk("freeze_frame", 64'(bus.frame_out), 64'(window(p0, msg1)));

        // Off: display drops on the next edge, position held.
        bus.mode = 2'b00;
        step_clk();
        chk("off_display_en", 64'(bus.display_en), 64'd0);
        chk("off_pos", 64'(bus.pos), 64'(p0));
        bus.msg_bits = msg0;
        run_frame(10);
        chk("off_frame_held", 64'(bus.frame_out), 64'(window(p0, msg1)));

        // Reset mid-scroll at pos 9.
        bus.mode = 2'b01;
        guard = 0;
        while (m_pos != 9 && guard < 40) begin
            run_frame(10);
            guard++;
        end
        chk("reach_pos9", 64'(bus.pos), 64'd9);
        repeat (3) step_clk();
        do_reset();
        repeat (6) step_clk();
        bus.frame_sync = 1'b1;
        step_clk();
        bus.frame_sync = 1'b0;
        chk("post_rst_pos", 64'(bus.pos), 64'd1);
        chk("post_rst_frame", 64'(bus.frame_out), 64'(window(1, msg0)));

        // Random mode, bitmap and frame_sync traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 47) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) bus.msg_bits = rand_msg();
            bus.frame_sync = ($urandom_range(0, 6) == 0);
            if (i % 1000 == 999) begin
                bus.frame_sync = 1'b0;
                do_reset();
            end else begin
                step_clk();
            end
        end
        bus.frame_sync = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
